// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size codes, FSM states and datapath width for the load/store unit.
package lsu_pkg;
  localparam int DATA_WIDTH = 32;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_e;
  typedef enum logic [2:0] {IDLE, LD, ST_WR, RMW_RD, RMW_WR, RESP} state_e;
endpackage

// File: rtl/load_store_unit_byte_lane_unit.sv
// byte_lane_unit: little-endian lane extract with sign/zero extension, and lane merge for sub-word stores.
module byte_lane_unit
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] ext_data,
  output logic [31:0] merged
);
  logic [4:0]  sh_b, sh_h;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    sh_b = {offset, 3'b000};
    sh_h = {offset[1], 4'b0000};
    b = 8'(rdata >> sh_b);
    h = 16'(rdata >> sh_h);
    ext_data = size == SZ_BYTE ? {{24{~is_unsigned & b[7]}}, b} :
               size == SZ_HALF ? {{16{~is_unsigned & h[15]}}, h} : rdata;
    merged = size == SZ_BYTE ? (old_word & ~(32'h0000_00ff << sh_b)) | ({24'd0, wdata[7:0]} << sh_b) :
             (old_word & ~(32'h0000_ffff << sh_h)) | ({16'd0, wdata[15:0]} << sh_h);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: drives a word-wide data memory for byte/half/word loads and stores, with RMW for sub-word stores.
module load_store_unit #(
  parameter int DATA_WIDTH   = lsu_pkg::DATA_WIDTH,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  busy,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [31:0]           mem_address,
  output logic [DATA_WIDTH-1:0] mem_in_data,
  input  logic [DATA_WIDTH-1:0] mem_out_data
);
  import lsu_pkg::*;
  state_e      state;
  logic [31:0] addr_q, wdata_q, buf_q, rdata_q, ext, merged;
  logic [1:0]  size_q;
  logic        uns_q, err_q, err;
  byte_lane_unit u_lane (
    .size(size_q), .is_unsigned(uns_q), .offset(addr_q[1:0]), .rdata(mem_out_data),
    .old_word(buf_q), .wdata(wdata_q), .ext_data(ext), .merged(merged)
  );
  always_comb begin
    err = (req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
          req_size == 2'b11 || {2'b00, req_addr[31:2]} >= 32'(MEMORY_DEPTH);
    busy = !reset && state != IDLE;
    resp_valid = !reset && state == RESP;
    resp_err = resp_valid && err_q;
    resp_rdata = resp_valid ? rdata_q : '0;
    mem_read_enable = !reset && (state == LD || state == RMW_RD);
    mem_write_enable = !reset && (state == ST_WR || state == RMW_WR);
    mem_address = busy ? {2'b00, addr_q[31:2]} : '0;
    mem_in_data = !mem_write_enable ? '0 : state == RMW_WR ? merged : wdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      buf_q <= '0;
      rdata_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          size_q <= req_size;
          uns_q <= req_unsigned;
          rdata_q <= '0;
          err_q <= err;
          state <= err ? RESP : !req_write ? LD : req_size == SZ_WORD ? ST_WR : RMW_RD;
        end
        LD: begin
          rdata_q <= ext;
          state <= RESP;
        end
        RMW_RD: begin
          buf_q <= mem_out_data;
          state <= RMW_WR;
        end
        ST_WR, RMW_WR: state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit against a behavioural word memory.
module tb_load_store_unit;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_write = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        busy, resp_valid, resp_err, mem_read_enable, mem_write_enable;
  logic [31:0] resp_rdata, mem_address, mem_in_data, mem_out_data;
  logic [31:0] mem [1024];
  logic        pl_en = 0;
  logic [9:0]  pl_idx = 0;
  logic [31:0] pl_data = 0;
  int          total = 0, bad = 0, lat, re, we, cnt;
  logic [31:0] rd;
  logic        er;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_in_data(mem_in_data), .mem_out_data(mem_out_data)
  );

  always #5 clk = ~clk;
  assign mem_out_data = mem_read_enable ? mem[mem_address[9:0]] : 32'd0;
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[9:0]] <= mem_in_data;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] d);
    pl_idx = idx; pl_data = d; pl_en = 1;
    @(negedge clk);
    pl_en = 0;
  endtask

  task automatic set_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] wd);
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd; req_valid = 1;
  endtask

  // Called at the first negedge after acceptance; counts cycles until resp_valid.
  task automatic wait_resp();
    lat = 1; re = int'(mem_read_enable); we = int'(mem_write_enable);
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
      re += int'(mem_read_enable);
      we += int'(mem_write_enable);
    end
    rd = resp_rdata; er = resp_err;
  endtask

  task automatic txn(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] wd);
    set_req(w, sz, u, a, wd);
    @(negedge clk);
    req_valid = 0;
    wait_resp();
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_we", 32'(mem_write_enable), 0);
    chk("rst_addr", mem_address, 0);
    reset = 0;
    preload(5, 32'h80FF7F01);
    preload(3, 32'hAABBCCDD);
    preload(8, 32'h11223344);
    preload(20, 32'h01020304);
    preload(21, 32'h0A0B0C0D);
    chk("idle_busy", 32'(busy), 0);

    txn(0, 2'b00, 0, 32'h15, 0);
    chk("lb15_data", rd, 32'h0000007F); chk("lb15_lat", lat, 2); chk("lb15_err", 32'(er), 0);
    txn(0, 2'b00, 0, 32'h16, 0);
    chk("lb16_data", rd, 32'hFFFFFFFF); chk("lb16_lat", lat, 2);
    txn(0, 2'b00, 1, 32'h17, 0);
    chk("lbu17_data", rd, 32'h00000080); chk("lbu17_lat", lat, 2);
    txn(0, 2'b01, 0, 32'h16, 0);
    chk("lh16_data", rd, 32'hFFFF80FF);
    txn(0, 2'b01, 1, 32'h14, 0);
    chk("lhu14_data", rd, 32'h00007F01);

    txn(1, 2'b01, 0, 32'h0E, 32'h00001234);
    chk("sh_lat", lat, 3); chk("sh_we_cycles", we, 1); chk("sh_re_cycles", re, 1);
    chk("sh_mem", mem[3], 32'h1234CCDD); chk("sh_rdata", rd, 0);

    txn(0, 2'b10, 0, 32'h21, 0);
    chk("lw_mis_err", 32'(er), 1); chk("lw_mis_data", rd, 0); chk("lw_mis_lat", lat, 1);
    chk("lw_mis_re", re, 0); chk("lw_mis_we", we, 0);
    txn(1, 2'b10, 0, 32'h1000, 32'h55555555);
    chk("sw_oor_err", 32'(er), 1); chk("sw_oor_we", we, 0); chk("sw_oor_mem0", mem[0], 32'h00000000);
    txn(0, 2'b11, 0, 32'h10, 0);
    chk("size11_err", 32'(er), 1);
    txn(0, 2'b01, 0, 32'h15, 0);
    chk("lh_mis_err", 32'(er), 1);
    txn(0, 2'b10, 0, 32'hFFC, 0);
    chk("lw_last_err", 32'(er), 0);

    // sw then lw held back-to-back: exactly one idle cycle between them
    set_req(1, 2'b10, 0, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    req_valid = 0;
    wait_resp();
    chk("sw_lat", lat, 2); chk("sw_we_cycles", we, 1); chk("sw_err", 32'(er), 0);
    set_req(0, 2'b10, 0, 32'h40, 0);
    cnt = 0;
    @(negedge clk);
    while (!busy && cnt < 8) begin cnt++; @(negedge clk); end
    chk("idle_gap", cnt, 1);
    req_valid = 0;
    wait_resp();
    chk("mem16", mem[16], 32'hDEADBEEF); chk("lw40_data", rd, 32'hDEADBEEF);
    @(negedge clk);

    // reset landing in RMW_WR must suppress the write
    set_req(1, 2'b00, 0, 32'h21, 32'h000000AA);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk("rmw_wr_reached", 32'(mem_write_enable), 1);
    reset = 1;
    #1 chk("rst_we_gated", 32'(mem_write_enable), 0);
    @(negedge clk);
    reset = 0;
    #1 chk("rst_idle", 32'(busy), 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); cnt += int'(resp_valid); end
    chk("rst_no_resp", cnt, 0); chk("rst_mem8", mem[8], 32'h11223344);

    // held request with a changing address: only the first is executed
    set_req(0, 2'b10, 0, 32'h50, 0);
    @(negedge clk);
    req_addr = 32'h54;
    wait_resp();
    chk("held_first", rd, 32'h01020304);
    cnt = 0;
    @(negedge clk);
    while (!busy && cnt < 8) begin cnt++; @(negedge clk); end
    chk("held_gap", cnt, 1);
    req_valid = 0;
    wait_resp();
    chk("held_second", rd, 32'h0A0B0C0D);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the processor's data-memory interface: accepts load/store requests from the MEM stage and drives the word-wide data memory's read_enable, write_enable, address and in_data, and consumes its out_data.
- Adds byte and halfword access (lb/lbu/lh/lhu/sb/sh) on top of the word-only memory. Sub-word stores use a two-cycle read-modify-write.
- Raises busy so the pipeline can stall while an access is in flight.

Parameters:
- DATA_WIDTH, 32, datapath width; the block supports only 32.
- MEMORY_DEPTH, 1024, number of words in the attached memory; sets the range check.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present; sampled only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal and raises an error.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- busy  output  1  high in every state except IDLE.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid: misaligned access, out-of-range address, or illegal size.
- mem_read_enable  output  1  to data memory read_enable.
- mem_write_enable  output  1  to data memory write_enable.
- mem_address  output  32  word index = req_addr[31:2], zero-extended.
- mem_in_data  output  32  write data to memory.
- mem_out_data  input  32  combinational read data from memory; zero when mem_read_enable is low.

Behaviour:
- Reset forces state IDLE and clears every captured register. While reset is high:
  - busy, resp_valid, resp_err and mem_write_enable are all 0.
  - resp_rdata, mem_read_enable, mem_address and mem_in_data are all 0.
- mem_write_enable is additionally gated by !reset, so reset asserted in RMW_WR or ST_WR never writes memory.
- Byte lanes are little-endian:
  - byte offset k = addr[1:0] selects bits [8k+7:8k];
  - halfword offset addr[1] selects [15:0] or [31:16].
- Error check in IDLE on acceptance. An error is any of:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - size = 11;
  - word index >= MEMORY_DEPTH.
- On error: no memory access, go to RESP with resp_err = 1 and resp_rdata = 0.
- State machine (request, address, data, size and unsigned flag are captured at acceptance):
  - IDLE: if req_valid and no error, go to LD for a load, ST_WR for a word store, or RMW_RD for a sub-word store. If req_valid with an error, go to RESP. Otherwise stay in IDLE.
  - LD: mem_read_enable = 1. Extract and extend the lane from mem_out_data, register it into resp_rdata, then go to RESP.
  - ST_WR: mem_write_enable = 1, mem_in_data = captured wdata, then go to RESP.
  - RMW_RD: mem_read_enable = 1. Register mem_out_data into the merge buffer, then go to RMW_WR.
  - RMW_WR: mem_write_enable = 1. mem_in_data = merge buffer with the selected lane replaced by wdata[7:0] or wdata[15:0]. Then go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then go to IDLE.
- Latency from the acceptance edge to resp_valid:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Back-to-back requests: a new request is accepted on the edge that leaves RESP for IDLE at the earliest, i.e. one idle cycle between responses.
- req_valid outside IDLE is ignored. The requester holds the request until busy is seen.
- Memory outputs are 0 in every state that does not drive them.
- mem_address holds the captured word index in all non-IDLE states.

Decomposition:
- Shared package lsu_pkg holds:
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state encoding IDLE, LD, ST_WR, RMW_RD, RMW_WR, RESP;
  - the DATA_WIDTH constant.
- One combinational sub-module, byte_lane_unit, performs lane extract with sign/zero extension and lane merge for stores.
- The FSM and all registers stay in load_store_unit.

Test Plan:
- Memory word 5 preloaded 0x80FF7F01. lb at addr 0x15 → resp_rdata 0x0000007F. lb at 0x16 → 0xFFFFFFFF. lbu at 0x17 → 0x00000080. Each response arrives 2 cycles after acceptance.
- Word 3 = 0xAABBCCDD. sh of wdata 0x00001234 at addr 0x0E → RMW read then write of 0x1234CCDD. mem_write_enable is high exactly one cycle. resp_valid arrives at +3.
- lw at 0x00000021 → resp_err = 1 and resp_rdata = 0 at +1, with no read or write enable asserted. sw at word index 1024 → resp_err = 1 and memory is unchanged.
- sw 0xDEADBEEF at 0x40 → one write of word 16. A following lw at 0x40 returns 0xDEADBEEF. busy is low for exactly one cycle between the two requests.
- reset asserted during RMW_WR of an sb → mem_write_enable stays 0, the target word is unchanged, the next state is IDLE, and no resp_valid follows.
- req_valid held high while busy with changing addresses → only the first request is executed. The second is accepted only after the return to IDLE.
